// File: rtl/scan_index_gen.sv
// Scan index generator feeding a 3-to-8 one-hot decoder: a prescaler produces step
// ticks, and on each tick sel advances up, down, ping-pong or holds.
module scan_index_gen #(
   parameter int TICK_DIV = 4,
   parameter int NUM_IDX  = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic [1:0] mode,
   input  logic       load,
   input  logic [2:0] load_val,
   output logic [2:0] sel,
   output logic       step,
   output logic       wrap,
   output logic       dir
);

   localparam int             CW       = $clog2(TICK_DIV) + 1;
   localparam logic [CW-1:0]  CNT_LAST = CW'(TICK_DIV - 1);
   localparam logic [2:0]     IDX_LAST = 3'(NUM_IDX - 1);
   localparam logic [2:0]     IDX_PEN  = 3'(NUM_IDX - 2);

   typedef enum logic [1:0] {
      MODE_UP   = 2'b00,
      MODE_DOWN = 2'b01,
      MODE_PING = 2'b10,
      MODE_HOLD = 2'b11
   } mode_t;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_t;

   logic [CW-1:0] r_cnt;
   logic [2:0]    r_sel;
   logic          r_step;
   logic          r_wrap;
   dir_t          r_dir;

   logic          w_tick;
   logic [2:0]    w_cur;
   logic [2:0]    w_load_sel;
   logic [2:0]    w_nxt_sel;
   logic          w_nxt_step;
   logic          w_nxt_wrap;
   dir_t          w_nxt_dir;

   assign w_tick     = en && (r_cnt == CNT_LAST);
   // Out-of-range indices behave as the last valid position.
   assign w_cur      = (r_sel > IDX_LAST) ? IDX_LAST : r_sel;
   assign w_load_sel = (load_val > IDX_LAST) ? IDX_LAST : load_val;

   always_comb begin
      w_nxt_sel  = w_cur;
      w_nxt_step = 1'b0;
      w_nxt_wrap = 1'b0;
      w_nxt_dir  = r_dir;
      case (mode_t'(mode))
         MODE_UP: begin
            w_nxt_step = 1'b1;
            if (w_cur == IDX_LAST) begin
               w_nxt_sel  = 3'd0;
               w_nxt_wrap = 1'b1;
            end else begin
               w_nxt_sel  = w_cur + 3'd1;
            end
         end
         MODE_DOWN: begin
            w_nxt_step = 1'b1;
            if (w_cur == 3'd0) begin
               w_nxt_sel  = IDX_LAST;
               w_nxt_wrap = 1'b1;
            end else begin
               w_nxt_sel  = w_cur - 3'd1;
            end
         end
         MODE_PING: begin
            w_nxt_step = 1'b1;
            if (r_dir == DIR_UP) begin
               if (w_cur == IDX_LAST) begin
                  w_nxt_sel  = IDX_PEN;
                  w_nxt_dir  = DIR_DOWN;
                  w_nxt_wrap = 1'b1;
               end else begin
                  w_nxt_sel  = w_cur + 3'd1;
               end
            end else begin
               if (w_cur == 3'd0) begin
                  w_nxt_sel  = 3'd1;
                  w_nxt_dir  = DIR_UP;
                  w_nxt_wrap = 1'b1;
               end else begin
                  w_nxt_sel  = w_cur - 3'd1;
               end
            end
         end
         MODE_HOLD: begin
            w_nxt_sel = r_sel;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt  <= '0;
         r_sel  <= 3'd0;
         r_step <= 1'b0;
         r_wrap <= 1'b0;
         r_dir  <= DIR_UP;
      end else if (load) begin
         // Load restarts the step period and wins over a coincident tick.
         r_cnt  <= '0;
         r_sel  <= w_load_sel;
         r_step <= 1'b0;
         r_wrap <= 1'b0;
      end else begin
         r_step <= 1'b0;
         r_wrap <= 1'b0;
         if (en) begin
            r_cnt <= w_tick ? '0 : r_cnt + CW'(1);
         end
         if (w_tick) begin
            r_sel  <= w_nxt_sel;
            r_step <= w_nxt_step;
            r_wrap <= w_nxt_wrap;
            r_dir  <= w_nxt_dir;
         end
      end
   end

   assign sel  = r_sel;
   assign step = r_step;
   assign wrap = r_wrap;
   assign dir  = r_dir;

endmodule

// File: tb/tb_scan_index_gen.sv
// Randomized bench for scan_index_gen: three instances with different geometries
// run from shared stimulus and are compared every cycle against a behavioural model.
module tb_scan_index_gen;

   localparam int TD [3] = '{4, 3, 1};
   localparam int NN [3] = '{8, 6, 2};

   logic       clk;
   logic       rst;
   logic       en;
   logic [1:0] mode;
   logic       load;
   logic [2:0] load_val;

   logic [2:0] d_sel  [3];
   logic       d_step [3];
   logic       d_wrap [3];
   logic       d_dir  [3];

   int m_sel  [3];
   int m_cnt  [3];
   int m_dir  [3];
   int m_step [3];
   int m_wrap [3];

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 0;

   scan_index_gen #(.TICK_DIV(4), .NUM_IDX(8)) u_dut_a (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .load_val(load_val),
      .sel(d_sel[0]), .step(d_step[0]), .wrap(d_wrap[0]), .dir(d_dir[0]));
   scan_index_gen #(.TICK_DIV(3), .NUM_IDX(6)) u_dut_b (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .load_val(load_val),
      .sel(d_sel[1]), .step(d_step[1]), .wrap(d_wrap[1]), .dir(d_dir[1]));
   scan_index_gen #(.TICK_DIV(1), .NUM_IDX(2)) u_dut_c (
      .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .load_val(load_val),
      .sel(d_sel[2]), .step(d_step[2]), .wrap(d_wrap[2]), .dir(d_dir[2]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s t=%0t observed=%0d expected=%0d", tag, $time, obs, exp);
      end
   endtask

   // Reference behaviour: prescaler as a cycle count, sel from the index rules.
   always @(posedge clk) begin : model
      int s, c, d, st, wr, n;
      for (int i = 0; i < 3; i++) begin
         n = NN[i];
         s = m_sel[i]; c = m_cnt[i]; d = m_dir[i]; st = 0; wr = 0;
         if (rst) begin
            s = 0; c = 0; d = 0;
         end else if (load) begin
            s = (int'(load_val) < n - 1) ? int'(load_val) : n - 1;
            c = 0;
         end else if (en) begin
            if (c == TD[i] - 1) begin
               c = 0;
               if (s > n - 1) s = n - 1;
               case (mode)
                  2'b00: begin st = 1; wr = (s == n - 1); s = (s + 1) % n; end
                  2'b01: begin st = 1; wr = (s == 0); s = (s + n - 1) % n; end
                  2'b10: begin
                     st = 1;
                     if (d == 0) begin
                        if (s == n - 1) begin s = n - 2; d = 1; wr = 1; end
                        else s = s + 1;
                     end else begin
                        if (s == 0) begin s = 1; d = 0; wr = 1; end
                        else s = s - 1;
                     end
                  end
                  default: ;
               endcase
            end else begin
               c = c + 1;
            end
         end
         m_sel[i]  <= s;
         m_cnt[i]  <= c;
         m_dir[i]  <= d;
         m_step[i] <= st;
         m_wrap[i] <= wr;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 3; i++) begin
            chk($sformatf("sel[%0d]", i),  int'(d_sel[i]),  m_sel[i]);
            chk($sformatf("step[%0d]", i), int'(d_step[i]), m_step[i]);
            chk($sformatf("wrap[%0d]", i), int'(d_wrap[i]), m_wrap[i]);
            chk($sformatf("dir[%0d]", i),  int'(d_dir[i]),  m_dir[i]);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Cycles until instance A pulses step, bounded.
   task automatic lat_to_step(output int k);
      k = 0;
      for (int j = 1; j <= 20; j++) begin
         cyc();
         if (d_step[0]) begin
            k = j;
            break;
         end
      end
   endtask

   initial begin
      int k;
      bit found;
      for (int i = 0; i < 3; i++) begin
         m_sel[i] = 0; m_cnt[i] = 0; m_dir[i] = 0; m_step[i] = 0; m_wrap[i] = 0;
      end
      rst = 1'b1; en = 1'b0; mode = 2'b00; load = 1'b0; load_val = 3'd0;
      @(posedge clk);
      chk_en = 1'b1;
      cyc();
      chk("rst_sel", int'(d_sel[0]), 0);
      chk("rst_step", int'(d_step[0]), 0);
      chk("rst_dir", int'(d_dir[0]), 0);
      rst = 1'b0; en = 1'b1; mode = 2'b00;

      // Up count through a full wrap, then down, then ping-pong.
      repeat (40) cyc();
      load = 1'b1; load_val = 3'd0; cyc(); load = 1'b0;
      mode = 2'b01;
      repeat (14) cyc();
      load = 1'b1; load_val = 3'd0; cyc(); load = 1'b0;
      mode = 2'b10;
      repeat (70) cyc();

      // Load on the tick edge: tick suppressed, period restarts.
      mode = 2'b00;
      for (int j = 0; j < 10 && m_cnt[0] != 3; j++) cyc();
      load = 1'b1; load_val = 3'd5; cyc(); load = 1'b0;
      chk("load_sel", int'(d_sel[0]), 5);
      chk("load_step", int'(d_step[0]), 0);
      lat_to_step(k);
      chk("load_tick_lat", k, 4);
      load = 1'b1; load_val = 3'd7; cyc(); load = 1'b0;
      chk("load_clamp6", int'(d_sel[1]), 5);
      chk("load_clamp2", int'(d_sel[2]), 1);

      // Prescaler freeze mid-period.
      for (int j = 0; j < 10 && m_cnt[0] != 2; j++) cyc();
      k = int'(d_sel[0]);
      en = 1'b0;
      repeat (10) cyc();
      chk("en_hold_sel", int'(d_sel[0]), k);
      en = 1'b1;
      lat_to_step(k);
      chk("en_resume_lat", k, 2);

      mode = 2'b11;
      repeat (20) cyc();

      // Reset in the middle of the ping-pong down leg.
      mode = 2'b10;
      found = 1'b0;
      for (int j = 0; j < 200; j++) begin
         cyc();
         if (d_sel[0] == 3'd4 && d_dir[0] == 1'b1) begin
            found = 1'b1;
            break;
         end
      end
      chk("pp_reach", int'(found), 1);
      rst = 1'b1; cyc(); rst = 1'b0;
      chk("pp_rst_sel", int'(d_sel[0]), 0);
      chk("pp_rst_dir", int'(d_dir[0]), 0);
      chk("pp_rst_wrap", int'(d_wrap[0]), 0);
      lat_to_step(k);
      chk("pp_rst_lat", k, 4);

      // Randomized mix of everything.
      for (int j = 0; j < 2000; j++) begin
         rst      = ($urandom_range(0, 199) == 0);
         load     = ($urandom_range(0, 29) == 0);
         load_val = 3'($urandom);
         en       = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 19) == 0) mode = 2'($urandom);
         cyc();
      end
      rst = 1'b0; load = 1'b0;
      cyc();
      chk_en = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
